dp_axi_mem_slave: RTL and testbench
===================================

# dp_axi_mem_slave

Single-port word memory with an AXI-Lite slave interface, attached directly downstream of the dot-product accelerator's AXI master port. It serves the accelerator's single-beat operand reads and result write-back. It gives the engine a cycle-accurate, latency-programmable memory target for both simulation and FPGA builds.

## Interface
- DEPTH_WORDS, 1024 — number of 32-bit words; power of 2, minimum 4.
- BASE_ADDR, 32'h0000_0000 — byte address of word 0; aligned to 4*DEPTH_WORDS.
- RD_LATENCY, 1 — extra wait cycles before RVALID; range 0–7.
- ACLK  in  1  clock; all logic rising-edge.
- ARESETn  in  1  reset; synchronous, active-low.
- ARVALID  in  1  read address valid.
- ARADDR  in  32  read byte address.
- ARREADY  out  1  read address accepted.
- RVALID  out  1  read data valid.
- RDATA  out  32  read data.
- RRESP  out  2  read response: 2'b00 OKAY, 2'b10 SLVERR.
- RREADY  in  1  master accepts read data.
- AWVALID  in  1  write address valid.
- AWADDR  in  32  write byte address.
- AWREADY  out  1  write address accepted.
- WVALID  in  1  write data valid.
- WDATA  in  32  write data; full-word writes only, no strobes.
- WREADY  out  1  write data accepted.
- BVALID  out  1  write response valid.
- BRESP  out  2  write response: 2'b00 or 2'b10.
- BREADY  in  1  master accepts response.

## Operation
- Word index = (addr − BASE_ADDR) >> 2. addr[1:0] is ignored.
- Read FSM states: R_IDLE, R_WAIT, R_RESP.
  - R_IDLE: ARREADY=1. An AR handshake latches the address.
  - After the handshake: go to R_WAIT if RD_LATENCY>0, else go to R_RESP.
  - R_WAIT: counts RD_LATENCY cycles, then goes to R_RESP.
  - Memory is sampled on the edge that enters R_RESP.
  - R_RESP: RVALID=1. RDATA and RRESP are held stable until RREADY. On the R handshake, return to R_IDLE.
- Write FSM states: W_IDLE, W_RESP.
  - W_IDLE: AWREADY=!aw_held and WREADY=!w_held.
  - AW and W are accepted independently, in either order or in the same cycle. Each is latched and its ready drops once captured.
  - When both are held, including when both are captured on the same edge, the memory is written on the next edge and the FSM enters W_RESP.
  - W_RESP: BVALID=1 and BRESP held until BREADY. The handshake clears both held flags and returns to W_IDLE.
- Read and write channels are fully independent and may be active concurrently.
- Same-edge collision (read sample and write commit to the same index): the read returns the old data (read-before-write).
- Memory contents are not reset and are X until written.

## Timing
- Reset: while ARESETn=0 at an edge, all outputs are 0 (ARREADY, AWREADY, WREADY, RVALID, BVALID, RDATA, RRESP, BRESP), both FSMs go idle, and the held flags clear.
- Ready outputs rise in the first cycle after the reset-release edge.
- Reset mid-transaction drops it:
  - No response is issued.
  - A write that has not reached its commit edge is not written.
- Read latency: AR handshake in cycle N gives RVALID first high in cycle N+1+RD_LATENCY.
- After the R handshake in cycle M, ARREADY is high in cycle M+1. Minimum read spacing is 2+RD_LATENCY cycles.
- Write latency: the later of the AW/W handshakes in cycle N gives BVALID in cycle N+1. Readiness returns the cycle after the B handshake.
- Backpressure: RVALID and BVALID stay high indefinitely while the master holds RREADY or BREADY low, with data and response stable.

## Configuration
- ERR_RESP_EN defined: an address outside [BASE_ADDR, BASE_ADDR+4*DEPTH_WORDS) gets RRESP/BRESP=2'b10 with RDATA=0. The write is discarded and handshake timing is unchanged.
- ERR_RESP_EN undefined: the index wraps modulo DEPTH_WORDS, and the response is always 2'b00.

## Test plan
- Reset, then write 32'hDEAD_BEEF to 0x10 with AW and W in the same cycle. Then read 0x10 with RD_LATENCY=1.
  - BVALID follows the handshake by 1 cycle and BRESP=00.
  - RVALID follows the AR handshake by 2 cycles, with RDATA=32'hDEAD_BEEF and RRESP=00.
- Send W 3 cycles before AW (address 0x20, data 32'h1234_5678).
  - WREADY drops after the W capture.
  - BVALID comes 1 cycle after the AW handshake.
  - A read of 0x20 returns 32'h1234_5678.
- Hold RREADY=0 for 5 cycles during a read.
  - RVALID and RDATA stay stable.
  - ARREADY stays 0 until the cycle after RREADY=1.
- Issue a read and write to 0x40 whose sample and commit land on the same edge (old value 32'h0000_0001, new value 32'h0000_0002).
  - The read returns 32'h0000_0001.
  - A subsequent read returns 32'h0000_0002.
- Access address BASE_ADDR+4*DEPTH_WORDS:
  - With ERR_RESP_EN: BRESP=10, RRESP=10, RDATA=0, and word 0 is unchanged.
  - Without ERR_RESP_EN: word 0 is written and the response is 00.
- Assert ARESETn=0 for 1 cycle while RVALID=1 and while AW is held without W.
  - All outputs are 0 during reset, and the readies are 1 on the next cycle.
  - No stale RVALID or BVALID appears, and memory is unchanged.

Source files
------------

// File: rtl/dp_axi_mem_slave.sv
// dp_axi_mem_slave: single-port 32-bit word memory behind an AXI-Lite slave port.
// Define ERR_RESP_EN to answer out-of-window accesses with SLVERR instead of wrapping the index.
module dp_axi_mem_slave #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned RD_LATENCY  = 1
) (
  input  logic        ACLK,
  input  logic        ARESETn,
  input  logic        ARVALID,
  input  logic [31:0] ARADDR,
  output logic        ARREADY,
  output logic        RVALID,
  output logic [31:0] RDATA,
  output logic [1:0]  RRESP,
  input  logic        RREADY,
  input  logic        AWVALID,
  input  logic [31:0] AWADDR,
  output logic        AWREADY,
  input  logic        WVALID,
  input  logic [31:0] WDATA,
  output logic        WREADY,
  output logic        BVALID,
  output logic [1:0]  BRESP,
  input  logic        BREADY
);

  localparam int unsigned IdxW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {RIdle, RWait, RResp} r_state_e;
  typedef enum logic {WIdle, WResp} w_state_e;

  r_state_e         r_state;
  w_state_e         w_state;
  logic [2:0]       r_cnt;
  logic [31:0]      ar_addr_q;
  logic [31:0]      aw_addr_q;
  logic [31:0]      w_data_q;
  logic             aw_held;
  logic             w_held;
  logic [31:0]      mem [DEPTH_WORDS];

  logic [31:0]      rd_addr;
  logic [31:0]      rd_off;
  logic [31:0]      rd_data;
  logic [IdxW-1:0]  rd_idx;
  logic             rd_ok;
  logic [31:0]      wr_addr;
  logic [31:0]      wr_off;
  logic [31:0]      wr_data;
  logic [IdxW-1:0]  wr_idx;
  logic             wr_ok;
  logic             ar_hs;
  logic             aw_hs;
  logic             w_hs;
  logic             commit;
  logic             unused_addr_bits;

  assign ar_hs = ARVALID && ARREADY;
  assign aw_hs = AWVALID && AWREADY;
  assign w_hs  = WVALID && WREADY;

  // With zero latency the sample happens on the AR handshake edge, so use the live address.
  assign rd_addr = (r_state == RIdle) ? ARADDR : ar_addr_q;
  assign rd_off  = rd_addr - BASE_ADDR;
  assign rd_idx  = rd_off[IdxW+1:2];

  // A channel captured on this same edge has not been latched yet; bypass the holding register.
  assign wr_addr = aw_held ? aw_addr_q : AWADDR;
  assign wr_data = w_held ? w_data_q : WDATA;
  assign wr_off  = wr_addr - BASE_ADDR;
  assign wr_idx  = wr_off[IdxW+1:2];

`ifdef ERR_RESP_EN
  assign rd_ok = (rd_off[31:IdxW+2] == '0);
  assign wr_ok = (wr_off[31:IdxW+2] == '0);
  assign unused_addr_bits = ^{rd_off[1:0], wr_off[1:0]};
`else
  assign rd_ok = 1'b1;
  assign wr_ok = 1'b1;
  assign unused_addr_bits = ^{rd_off[1:0], wr_off[1:0], rd_off[31:IdxW+2], wr_off[31:IdxW+2]};
`endif

  assign rd_data = rd_ok ? mem[rd_idx] : 32'h0;
  assign commit  = (w_state == WIdle) && (aw_held || aw_hs) && (w_held || w_hs);

  // Memory array has no reset; the nonblocking write gives read-before-write on collisions.
  always_ff @(posedge ACLK) begin
    if (ARESETn && commit && wr_ok) begin
      mem[wr_idx] <= wr_data;
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      r_state   <= RIdle;
      r_cnt     <= 3'd0;
      ar_addr_q <= 32'h0;
      ARREADY   <= 1'b0;
      RVALID    <= 1'b0;
      RDATA     <= 32'h0;
      RRESP     <= 2'b00;
    end else begin
      unique case (r_state)
        RIdle: begin
          if (ar_hs) begin
            ARREADY   <= 1'b0;
            ar_addr_q <= ARADDR;
            if (RD_LATENCY == 0) begin
              RVALID  <= 1'b1;
              RDATA   <= rd_data;
              RRESP   <= rd_ok ? 2'b00 : 2'b10;
              r_state <= RResp;
            end else begin
              r_cnt   <= 3'(RD_LATENCY - 1);
              r_state <= RWait;
            end
          end else begin
            ARREADY <= 1'b1;
          end
        end
        RWait: begin
          if (r_cnt == 3'd0) begin
            RVALID  <= 1'b1;
            RDATA   <= rd_data;
            RRESP   <= rd_ok ? 2'b00 : 2'b10;
            r_state <= RResp;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        RResp: begin
          if (RREADY) begin
            RVALID  <= 1'b0;
            ARREADY <= 1'b1;
            r_state <= RIdle;
          end
        end
        default: r_state <= RIdle;
      endcase
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      w_state   <= WIdle;
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      aw_addr_q <= 32'h0;
      w_data_q  <= 32'h0;
      AWREADY   <= 1'b0;
      WREADY    <= 1'b0;
      BVALID    <= 1'b0;
      BRESP     <= 2'b00;
    end else begin
      unique case (w_state)
        WIdle: begin
          if (aw_hs) begin
            aw_held   <= 1'b1;
            aw_addr_q <= AWADDR;
          end
          if (w_hs) begin
            w_held   <= 1'b1;
            w_data_q <= WDATA;
          end
          AWREADY <= !(aw_held || aw_hs);
          WREADY  <= !(w_held || w_hs);
          if (commit) begin
            BVALID  <= 1'b1;
            BRESP   <= wr_ok ? 2'b00 : 2'b10;
            w_state <= WResp;
          end
        end
        WResp: begin
          if (BREADY) begin
            BVALID  <= 1'b0;
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            AWREADY <= 1'b1;
            WREADY  <= 1'b1;
            w_state <= WIdle;
          end
        end
        default: w_state <= WIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_dp_axi_mem_slave.sv
// Self-checking bench for dp_axi_mem_slave: directed vector table, corner sequences, random traffic.
module tb_dp_axi_mem_slave;

  localparam int unsigned DEPTH = 64;
  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int unsigned RDL   = 1;
`ifdef ERR_RESP_EN
  localparam logic [1:0]  OOR_RESP = 2'b10;
  localparam bit          ERR_EN   = 1'b1;
`else
  localparam logic [1:0]  OOR_RESP = 2'b00;
  localparam bit          ERR_EN   = 1'b0;
`endif

  logic        ACLK = 1'b0;
  logic        ARESETn = 1'b0;
  logic        ARVALID = 1'b0;
  logic [31:0] ARADDR = 32'h0;
  logic        ARREADY;
  logic        RVALID;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RREADY = 1'b0;
  logic        AWVALID = 1'b0;
  logic [31:0] AWADDR = 32'h0;
  logic        AWREADY;
  logic        WVALID = 1'b0;
  logic [31:0] WDATA = 32'h0;
  logic        WREADY;
  logic        BVALID;
  logic [1:0]  BRESP;
  logic        BREADY = 1'b0;

  always #5 ACLK = ~ACLK;

  dp_axi_mem_slave #(
    .DEPTH_WORDS(DEPTH),
    .BASE_ADDR  (BASE),
    .RD_LATENCY (RDL)
  ) dut (
    .ACLK   (ACLK),
    .ARESETn(ARESETn),
    .ARVALID(ARVALID),
    .ARADDR (ARADDR),
    .ARREADY(ARREADY),
    .RVALID (RVALID),
    .RDATA  (RDATA),
    .RRESP  (RRESP),
    .RREADY (RREADY),
    .AWVALID(AWVALID),
    .AWADDR (AWADDR),
    .AWREADY(AWREADY),
    .WVALID (WVALID),
    .WDATA  (WDATA),
    .WREADY (WREADY),
    .BVALID (BVALID),
    .BRESP  (BRESP),
    .BREADY (BREADY)
  );

  int errors = 0;
  int checks = 0;
  logic [31:0] model_mem [DEPTH];

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          aw_dly;
    int          w_dly;
    int          b_dly;
    int          r_dly;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference model: window test and modulo index from plain address arithmetic.
  function automatic bit in_window(input logic [31:0] a);
    return (a >= BASE) && (a < BASE + 4 * DEPTH);
  endfunction

  function automatic int unsigned word_of(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return (off / 4) % DEPTH;
  endfunction

  function automatic void model_write(input logic [31:0] a, input logic [31:0] d);
    if (ERR_EN && !in_window(a)) return;
    model_mem[word_of(a)] = d;
  endfunction

  function automatic logic [1:0] model_resp(input logic [31:0] a);
    return (ERR_EN && !in_window(a)) ? 2'b10 : 2'b00;
  endfunction

  function automatic logic [31:0] model_rdata(input logic [31:0] a);
    return (ERR_EN && !in_window(a)) ? 32'h0 : model_mem[word_of(a)];
  endfunction

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input int aw_dly,
                          input int w_dly, input int b_dly, input logic [1:0] exp_resp);
    bit aw_done, w_done, aw_hs, w_hs;
    int n;
    aw_done = 0;
    w_done  = 0;
    n       = 0;
    while (!(aw_done && w_done) && n < 50) begin
      AWADDR  = addr;
      WDATA   = data;
      AWVALID = !aw_done && (n >= aw_dly);
      WVALID  = !w_done && (n >= w_dly);
      aw_hs   = AWVALID && AWREADY;
      w_hs    = WVALID && WREADY;
      @(posedge ACLK); #1;
      n++;
      aw_done |= aw_hs;
      w_done  |= w_hs;
      if (aw_done != w_done) check("ready_drop", {AWREADY, WREADY}, {~aw_done, ~w_done});
    end
    AWVALID = 1'b0;
    WVALID  = 1'b0;
    check("w_handshakes", {aw_done, w_done}, 2'b11);
    for (int i = 0; i <= b_dly; i++) begin
      check("b_beat", {BVALID, BRESP, AWREADY, WREADY}, {1'b1, exp_resp, 2'b00});
      if (i == b_dly) BREADY = 1'b1;
      @(posedge ACLK); #1;
    end
    BREADY = 1'b0;
    check("ready_after_b", {BVALID, AWREADY, WREADY}, 3'b011);
  endtask

  task automatic do_read(input logic [31:0] addr, input int r_dly, input logic [31:0] exp_data,
                         input logic [1:0] exp_resp);
    bit hs;
    int n;
    ARADDR  = addr;
    ARVALID = 1'b1;
    n       = 0;
    do begin
      hs = ARREADY;
      @(posedge ACLK); #1;
      n++;
    end while (!hs && n < 50);
    ARVALID = 1'b0;
    check("ar_handshake", hs, 1);
    n = 1;
    while (!RVALID && n < 50) begin
      @(posedge ACLK); #1;
      n++;
    end
    check("r_latency", n, RDL + 1);
    for (int i = 0; i <= r_dly; i++) begin
      check("r_beat", {ARREADY, RVALID, RDATA, RRESP}, {1'b0, 1'b1, exp_data, exp_resp});
      if (i == r_dly) RREADY = 1'b1;
      @(posedge ACLK); #1;
    end
    RREADY = 1'b0;
    check("ready_after_r", {ARREADY, RVALID}, 2'b10);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, d;

    vecs[0] = '{BASE + 32'h10, 32'hDEAD_BEEF, 0, 0, 0, 0, 2'b00, 32'hDEAD_BEEF};
    vecs[1] = '{BASE + 32'h20, 32'h1234_5678, 3, 0, 0, 0, 2'b00, 32'h1234_5678};
    vecs[2] = '{BASE + 32'h30, 32'hA5A5_5A5A, 0, 2, 2, 5, 2'b00, 32'hA5A5_5A5A};
    vecs[3] = '{BASE + 32'h37, 32'h0F0F_F0F0, 1, 1, 0, 1, 2'b00, 32'h0F0F_F0F0};
    vecs[4] = '{BASE + 4 * DEPTH - 4, 32'hFFFF_0001, 2, 1, 1, 1, 2'b00, 32'hFFFF_0001};
    vecs[5] = '{BASE + 4 * DEPTH, 32'h7777_7777, 0, 0, 0, 0, OOR_RESP,
                ERR_EN ? 32'h0 : 32'h7777_7777};
    vecs[6] = '{BASE - 4, 32'h5555_AAAA, 1, 0, 0, 2, OOR_RESP,
                ERR_EN ? 32'h0 : 32'h5555_AAAA};

    repeat (2) @(posedge ACLK);
    #1;
    check("reset_outputs", {ARREADY, AWREADY, WREADY, RVALID, BVALID, RDATA, RRESP, BRESP}, 0);
    ARESETn = 1'b1;
    @(posedge ACLK); #1;
    check("ready_after_reset", {ARREADY, AWREADY, WREADY, RVALID, BVALID}, 5'b11100);

    for (int i = 0; i < 7; i++) begin
      do_write(vecs[i].addr, vecs[i].data, vecs[i].aw_dly, vecs[i].w_dly, vecs[i].b_dly,
               vecs[i].exp_resp);
      model_write(vecs[i].addr, vecs[i].data);
      do_read(vecs[i].addr, vecs[i].r_dly, vecs[i].exp_rdata, vecs[i].exp_resp);
    end

    // One-past-the-end access: error response or wrap onto word 0.
    do_write(BASE, 32'h1111_0000, 0, 0, 0, 2'b00);
    model_write(BASE, 32'h1111_0000);
    do_write(BASE + 4 * DEPTH, 32'h2222_0000, 0, 0, 0, OOR_RESP);
    model_write(BASE + 4 * DEPTH, 32'h2222_0000);
    do_read(BASE, 0, ERR_EN ? 32'h1111_0000 : 32'h2222_0000, 2'b00);

    // Read sample and write commit on the same edge.
    do_write(BASE + 32'h40, 32'h0000_0001, 0, 0, 0, 2'b00);
    model_write(BASE + 32'h40, 32'h0000_0001);
    ARADDR  = BASE + 32'h40;
    ARVALID = 1'b1;
    check("coll_arready", ARREADY, 1);
    @(posedge ACLK); #1;
    ARVALID = 1'b0;
    AWADDR  = BASE + 32'h40;
    WDATA   = 32'h0000_0002;
    AWVALID = 1'b1;
    WVALID  = 1'b1;
    check("coll_wready", {AWREADY, WREADY}, 2'b11);
    @(posedge ACLK); #1;
    AWVALID = 1'b0;
    WVALID  = 1'b0;
    check("coll_old_data", {RVALID, RDATA, RRESP}, {1'b1, 32'h0000_0001, 2'b00});
    check("coll_bresp", {BVALID, BRESP}, {1'b1, 2'b00});
    RREADY = 1'b1;
    BREADY = 1'b1;
    @(posedge ACLK); #1;
    RREADY = 1'b0;
    BREADY = 1'b0;
    model_write(BASE + 32'h40, 32'h0000_0002);
    do_read(BASE + 32'h40, 0, 32'h0000_0002, 2'b00);

    // Reset while RVALID is up and AW is held without W.
    do_write(BASE + 32'h50, 32'hCAFE_0050, 0, 0, 0, 2'b00);
    model_write(BASE + 32'h50, 32'hCAFE_0050);
    ARADDR  = BASE + 32'h10;
    ARVALID = 1'b1;
    AWADDR  = BASE + 32'h50;
    AWVALID = 1'b1;
    WDATA   = 32'hBAD0_0BAD;
    @(posedge ACLK); #1;
    ARVALID = 1'b0;
    AWVALID = 1'b0;
    check("aw_held_ready", {AWREADY, WREADY}, 2'b01);
    @(posedge ACLK); #1;
    check("pre_reset_rvalid", RVALID, 1);
    ARESETn = 1'b0;
    @(posedge ACLK); #1;
    check("mid_reset_outputs", {ARREADY, AWREADY, WREADY, RVALID, BVALID, RDATA, RRESP, BRESP}, 0);
    ARESETn = 1'b1;
    @(posedge ACLK); #1;
    check("post_reset_ready", {ARREADY, AWREADY, WREADY, RVALID, BVALID}, 5'b11100);
    repeat (3) begin
      @(posedge ACLK); #1;
      check("no_stale_resp", {RVALID, BVALID}, 2'b00);
    end
    do_read(BASE + 32'h50, 0, 32'hCAFE_0050, 2'b00);

    // Fill every word so random reads always have a defined expectation.
    for (int i = 0; i < DEPTH; i++) begin
      a = BASE + 4 * i;
      d = $urandom;
      do_write(a, d, 0, 0, 0, 2'b00);
      model_write(a, d);
    end

    for (int i = 0; i < 60; i++) begin
      a = BASE - 8 + $urandom_range(0, 4 * DEPTH + 16);
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom;
        do_write(a, d, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2),
                 model_resp(a));
        model_write(a, d);
      end else begin
        do_read(a, $urandom_range(0, 3), model_rdata(a), model_resp(a));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
